// File: rtl/cpu_run_ctrl_if.sv
// Host-side command channel and register-dump stream of the CPU run/debug controller.
// The host drives commands and dump backpressure; the controller answers.
`timescale 1ns/1ps
interface cpu_run_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  modport master (
    output cmd_valid, cmd_op, dump_ready,
    input  cmd_ready, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  cmd_valid, cmd_op, dump_ready,
    output cmd_ready, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/debug controller: gates the CPU clock-enable for run, halt, single-step,
// PC breakpoint and cycle budget, and streams the register file out on request.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_HALT | CPU stopped, waiting for a command (reset state)
//   ST_RUN  | free-running until breakpoint, cycle budget or HALT command
//   ST_STEP | exactly one enabled cycle, then back to halt
//   ST_DUMP | scanning registers 0..31 out on the dump stream
`timescale 1ns/1ps
module cpu_run_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  cpu_run_ctrl_if.slave    bus,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  input  logic [4:0]       dbg_sel,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP, ST_DUMP} state_t;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_HALT = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;

  localparam logic [1:0] CAUSE_CMD   = 2'd0;
  localparam logic [1:0] CAUSE_BP    = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_STEP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state, state_nxt;
  logic [1:0]  cause_nxt;
  logic        bp_mask;
  logic [5:0]  rd_idx;
  logic        cmd_acc, halt_req, limit_hit, bp_hit;
  logic        words_left, dump_load, dump_last;

  assign cmd_acc    = bus.cmd_valid && bus.cmd_ready;
  assign halt_req   = cmd_acc && (bus.cmd_op == OP_HALT);
  assign limit_hit  = (cycle_limit != '0) && (cycle_cnt >= cycle_limit);
  assign bp_hit     = bp_en && (pc == bp_addr) && !bp_mask;
  // rd_idx[5] set means all 32 words have been loaded into the output register
  assign words_left = !rd_idx[5];
  assign dump_load  = (state == ST_DUMP) && (!bus.dump_valid || bus.dump_ready) && words_left;
  assign dump_last  = (state == ST_DUMP) && bus.dump_valid && bus.dump_ready &&
                      (bus.dump_idx == 5'd31) && !words_left;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_HALT;
      halt_cause <= CAUSE_CMD;
    end else begin
      state      <= state_nxt;
      halt_cause <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = halt_cause;
    case (state)
      ST_HALT: begin
        if (cmd_acc) begin
          case (bus.cmd_op)
            OP_RUN:  state_nxt = ST_RUN;
            OP_STEP: state_nxt = ST_STEP;
            OP_DUMP: state_nxt = ST_DUMP;
            default: state_nxt = ST_HALT;
          endcase
        end
      end
      ST_RUN: begin
        if (bp_hit) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_BP;
        end else if (limit_hit) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_LIMIT;
        end else if (halt_req) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_CMD;
        end
      end
      ST_STEP: begin
        state_nxt = ST_HALT;
        cause_nxt = limit_hit ? CAUSE_LIMIT : CAUSE_STEP;
      end
      ST_DUMP: begin
        if (dump_last) state_nxt = ST_HALT;
      end
      default: state_nxt = ST_HALT;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == ST_HALT) || (state == ST_RUN);
    halted        = (state == ST_HALT);
    reg_sel       = (state == ST_DUMP) ? rd_idx[4:0] : dbg_sel;
    case (state)
      ST_RUN:  cpu_en = !bp_hit && !limit_hit && !halt_req;
      ST_STEP: cpu_en = !limit_hit;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bp_mask        <= 1'b0;
      cycle_cnt      <= '0;
      rd_idx         <= 6'd0;
      bus.dump_valid <= 1'b0;
      bus.dump_idx   <= 5'd0;
      bus.dump_data  <= 32'd0;
    end else begin
      // Masks the breakpoint for the first RUN cycle so a resume executes the bp instruction
      bp_mask <= (state == ST_HALT) && (state_nxt == ST_RUN);
      if (cpu_en && (cycle_cnt != CNT_MAX)) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (dump_load) begin
        bus.dump_data  <= (rd_idx == 6'd0) ? 32'd0 : reg_data;
        bus.dump_idx   <= rd_idx[4:0];
        bus.dump_valid <= 1'b1;
        rd_idx         <= rd_idx + 6'd1;
      end else if (bus.dump_valid && bus.dump_ready) begin
        bus.dump_valid <= 1'b0;
      end
      if (dump_last) rd_idx <= 6'd0;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: PC and register-file stand-ins, scenario-level expectations
// derived from breakpoint address, cycle budget, step count and dump contents.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
  localparam int CNT_W = 12;
  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_HALT = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             bp_en = 1'b0;
  logic [31:0]      bp_addr = 32'd0;
  logic [CNT_W-1:0] cycle_limit = '0;
  logic [31:0]      pc;
  logic             cpu_en;
  logic [4:0]       dbg_sel = 5'd0;
  logic [4:0]       reg_sel;
  logic [31:0]      reg_data;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int exp_cnt = 0;

  cpu_run_ctrl_if bus();

  cpu_run_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .bp_en(bp_en), .bp_addr(bp_addr), .cycle_limit(cycle_limit),
    .pc(pc), .cpu_en(cpu_en), .dbg_sel(dbg_sel), .reg_sel(reg_sel),
    .reg_data(reg_data), .halted(halted), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // CPU stand-ins: PC advances 4 per enabled edge, register i reads 0x1000+i
  assign reg_data = 32'h1000 + {27'd0, reg_sel};
  always @(posedge clk or negedge rstn)
    if (!rstn) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;

  always @(negedge clk) if (rstn && cpu_en) pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    dbg_sel = 5'($urandom_range(0, 31));
  endtask

  task automatic send_cmd(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    next_cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cpu_en"},  64'(cpu_en), 64'd0);
    check({tag, "_rdy"},     64'(bus.cmd_ready), 64'd1);
    check({tag, "_halted"},  64'(halted), 64'd1);
    check({tag, "_cause"},   64'(halt_cause), 64'd0);
    check({tag, "_cnt"},     64'(cycle_cnt), 64'd0);
    check({tag, "_dvalid"},  64'(bus.dump_valid), 64'd0);
    check({tag, "_didx"},    64'(bus.dump_idx), 64'd0);
    check({tag, "_ddata"},   64'(bus.dump_data), 64'd0);
    check({tag, "_regsel"},  64'(reg_sel), 64'(dbg_sel));
  endtask

  task automatic run_dump(input bit rand_ready, input logic [1:0] cause0, input string tag);
    logic [4:0]  q_idx[$];
    logic [31:0] q_dat[$];
    logic [4:0]  h_idx;
    logic [31:0] h_dat;
    bit          held = 0;
    int          cyc = 0;
    bus.dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    send_cmd(OP_DUMP);
    while (!halted && cyc < 400) begin
      @(negedge clk);
      if (!rand_ready && cyc <= 1) check({tag, "_first_valid"}, 64'(bus.dump_valid), 64'(cyc));
      if (held) begin
        check({tag, "_hold_valid"}, 64'(bus.dump_valid), 64'd1);
        check({tag, "_hold_idx"},   64'(bus.dump_idx), 64'(h_idx));
        check({tag, "_hold_data"},  64'(bus.dump_data), 64'(h_dat));
      end
      if (bus.dump_valid && bus.dump_ready) begin
        q_idx.push_back(bus.dump_idx);
        q_dat.push_back(bus.dump_data);
      end
      held  = bus.dump_valid && !bus.dump_ready;
      h_idx = bus.dump_idx;
      h_dat = bus.dump_data;
      next_cyc();
      cyc++;
      bus.dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check({tag, "_halted"}, 64'(halted), 64'd1);
    if (!rand_ready) check({tag, "_cycles"}, 64'(cyc), 64'd33);
    check({tag, "_words"}, 64'(q_idx.size()), 64'd32);
    for (int i = 0; i < q_idx.size() && i < 32; i++) begin
      check({tag, "_idx"},  64'(q_idx[i]), 64'(i));
      check({tag, "_data"}, 64'(q_dat[i]), (i == 0) ? 64'd0 : 64'(32'h1000 + i));
    end
    check({tag, "_cause"}, 64'(halt_cause), 64'(cause0));
    check({tag, "_valid_end"}, 64'(bus.dump_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, k, c, r, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_RUN;
    bus.dump_ready = 1'b0;
    dbg_sel = 5'd19;
    #3;
    check_reset("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    next_cyc();

    // Breakpoint at 0x48 from PC 0
    bp_en = 1'b1; bp_addr = 32'h48; cycle_limit = '0;
    p0 = pulses;
    send_cmd(OP_RUN);
    c = 0;
    while (pc != bp_addr && c < 200) begin next_cyc(); c++; end
    @(negedge clk);
    check("bp_pc", 64'(pc), 64'h48);
    check("bp_stop_en", 64'(cpu_en), 64'd0);
    next_cyc();
    exp_cnt = 32'h48 / 4;
    check("bp_halted", 64'(halted), 64'd1);
    check("bp_cause", 64'(halt_cause), 64'd1);
    check("bp_cnt", 64'(cycle_cnt), 64'(exp_cnt));
    check("bp_pulses", 64'(pulses - p0), 64'(exp_cnt));

    // Resume from breakpoint, with ignored commands sprinkled into the run
    k = $urandom_range(5, 40);
    send_cmd(OP_RUN);
    @(negedge clk);
    check("resume_first_en", 64'(cpu_en), 64'd1);
    for (int i = 1; i <= k; i++) begin
      next_cyc();
      if (i == 1) check("resume_pc", 64'(pc), 64'h4C);
      if (i < k) begin
        r = $urandom_range(0, 2);
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op = (r == 0) ? OP_RUN : (r == 1) ? OP_STEP : OP_DUMP;
      end
    end
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_HALT;
    @(negedge clk);
    check("halt_cmd_en", 64'(cpu_en), 64'd0);
    next_cyc();
    bus.cmd_valid = 1'b0;
    exp_cnt += k;
    check("resume_halted", 64'(halted), 64'd1);
    check("resume_cause", 64'(halt_cause), 64'd0);
    check("resume_cnt", 64'(cycle_cnt), 64'(exp_cnt));
    check("resume_pc_end", 64'(pc), 64'(32'h48 + 4 * k));

    // Cycle budget
    bp_en = 1'b0; cycle_limit = 12'd2000;
    p0 = pulses;
    send_cmd(OP_RUN);
    c = 0;
    while (!halted && c < 2500) begin next_cyc(); c++; end
    check("lim_halted", 64'(halted), 64'd1);
    check("lim_cnt", 64'(cycle_cnt), 64'd2000);
    check("lim_cause", 64'(halt_cause), 64'd2);
    check("lim_pulses", 64'(pulses - p0), 64'(2000 - exp_cnt));
    exp_cnt = 2000;
    p0 = pulses;
    send_cmd(OP_RUN);
    @(negedge clk);
    check("lim_rerun_en", 64'(cpu_en), 64'd0);
    next_cyc();
    check("lim_rerun_halted", 64'(halted), 64'd1);
    check("lim_rerun_pulses", 64'(pulses - p0), 64'd0);

    // Three back-to-back steps, breakpoint armed on the current PC (ignored in STEP)
    cycle_limit = '0; bp_en = 1'b1; bp_addr = pc;
    p0 = pulses;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_STEP;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("step_rdy_halt", 64'(bus.cmd_ready), 64'd1);
      next_cyc();
      if (i == 2) bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("step_rdy", 64'(bus.cmd_ready), 64'd0);
      check("step_en", 64'(cpu_en), 64'd1);
      next_cyc();
    end
    exp_cnt += 3;
    check("step_halted", 64'(halted), 64'd1);
    check("step_cause", 64'(halt_cause), 64'd3);
    check("step_pulses", 64'(pulses - p0), 64'd3);
    check("step_cnt", 64'(cycle_cnt), 64'(exp_cnt));

    // Step with the budget already exhausted
    bp_en = 1'b0; cycle_limit = CNT_W'(exp_cnt);
    send_cmd(OP_STEP);
    @(negedge clk);
    check("step_lim_en", 64'(cpu_en), 64'd0);
    next_cyc();
    check("step_lim_cause", 64'(halt_cause), 64'd2);
    check("step_lim_cnt", 64'(cycle_cnt), 64'(exp_cnt));
    cycle_limit = '0;

    // Dumps: full-rate then random backpressure
    run_dump(1'b0, 2'd2, "dump_fast");
    run_dump(1'b1, 2'd2, "dump_rand");

    // Reset in the middle of a dump
    bus.dump_ready = 1'b1;
    send_cmd(OP_DUMP);
    c = 0;
    do begin
      @(negedge clk);
      r = (bus.dump_valid && bus.dump_idx == 5'd10) ? 1 : 0;
      c++;
      if (r == 0) next_cyc();
    end while (r == 0 && c < 40);
    check("mid_reached10", 64'(r), 64'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_reset("mid_reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_cnt = 0;
    next_cyc();
    run_dump(1'b1, 2'd0, "dump_after_rst");
    @(negedge clk);
    check("regsel_dbg", 64'(reg_sel), 64'(dbg_sel));

    // Random breakpoint from PC 0
    n = $urandom_range(3, 60);
    bp_en = 1'b1; bp_addr = 32'(4 * n);
    send_cmd(OP_RUN);
    c = 0;
    while (pc != bp_addr && c < 200) begin next_cyc(); c++; end
    @(negedge clk);
    check("rbp_stop_en", 64'(cpu_en), 64'd0);
    next_cyc();
    check("rbp_cause", 64'(halt_cause), 64'd1);
    check("rbp_cnt", 64'(cycle_cnt), 64'(n));

    // Counter saturation
    bp_en = 1'b0;
    send_cmd(OP_RUN);
    repeat (4200) next_cyc();
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_HALT;
    next_cyc();
    bus.cmd_valid = 1'b0;
    check("sat_halted", 64'(halted), 64'd1);
    check("sat_cnt", 64'(cycle_cnt), 64'hFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
